// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline latches: stage state, control-field
// bit positions and the per-latch bubble / clear-mask constants.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } pstate_t;

  localparam int CTRL_WIDTH = 16;

  // Control-field bit positions shared by the hazard unit and the latches
  localparam int CTRL_REGWR_BIT    = 0;
  localparam int CTRL_DWEN_BIT     = 1;
  localparam int CTRL_DREN_BIT     = 2;
  localparam int CTRL_RDSEL_LO_BIT = 3;
  localparam int CTRL_RDSEL_HI_BIT = 4;
  localparam int CTRL_PCSRC_LO_BIT = 5;
  localparam int CTRL_PCSRC_HI_BIT = 6;
  localparam int CTRL_HALT_BIT     = 7;

  // NOP/RTYPE pattern loaded into a latch that carries no instruction
  localparam logic [CTRL_WIDTH-1:0] NOP_BUBBLE_CTRL = 16'h0033;

  // Memory request bits dropped once the data cache reports a hit
  localparam logic [CTRL_WIDTH-1:0] MEMREQ_MASK =
    (CTRL_WIDTH'(1) << CTRL_DWEN_BIT) | (CTRL_WIDTH'(1) << CTRL_DREN_BIT);

  localparam logic [CTRL_WIDTH-1:0] IFID_BUBBLE_CTRL  = NOP_BUBBLE_CTRL;
  localparam logic [CTRL_WIDTH-1:0] IFID_CLR_MASK     = '0;
  localparam logic [CTRL_WIDTH-1:0] IDEX_BUBBLE_CTRL  = NOP_BUBBLE_CTRL;
  localparam logic [CTRL_WIDTH-1:0] IDEX_CLR_MASK     = '0;
  localparam logic [CTRL_WIDTH-1:0] EXMEM_BUBBLE_CTRL = NOP_BUBBLE_CTRL;
  localparam logic [CTRL_WIDTH-1:0] EXMEM_CLR_MASK    = MEMREQ_MASK;
  localparam logic [CTRL_WIDTH-1:0] MEMWB_BUBBLE_CTRL = NOP_BUBBLE_CTRL;
  localparam logic [CTRL_WIDTH-1:0] MEMWB_CLR_MASK    = '0;

  // Number of entries held by a stage in the given state
  function automatic logic [1:0] occ_of(input pstate_t s);
    case (s)
      MAIN:    occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Second-entry skid register plus the registered upstream ready, which
// drops whenever the stage is about to hold two entries.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              load,
  input  pstate_t           next_state,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [DATA_W-1:0] skid_data,
  output logic [CTRL_W-1:0] skid_ctrl,
  output logic              in_ready
);

  // Skid entry: cleared by flush, captured when the output is stalled
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (load) begin
      skid_data <= in_data;
      skid_ctrl <= in_ctrl;
    end
  end

  // Registered ready so upstream never sees a path from this cycle's inputs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      in_ready <= 1'b1;
    end else begin
      in_ready <= flush | (next_state != FULL);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush, bubble insertion,
// selective control-bit clearing and an optional 2-entry skid buffer.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 128,
  parameter int                CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter logic [CTRL_W-1:0] CLR_MASK    = '0,
  parameter int                SKID        = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              clr_ctrl,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  pstate_t           state;
  pstate_t           next_state;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic [CTRL_W-1:0] ctrl_q;
  logic [CTRL_W-1:0] ctrl_d;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              skid_load;
  logic              in_xfer;
  logic              out_xfer;

  assign out_valid = (state != EMPTY);
  assign out_data  = data_q;
  assign out_ctrl  = ctrl_q;
  assign occupancy = occ_of(state);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      pipe_skid_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_skid (
        .CLK        (CLK),
        .nRST       (nRST),
        .flush      (flush),
        .load       (skid_load),
        .next_state (next_state),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .skid_data  (skid_data),
        .skid_ctrl  (skid_ctrl),
        .in_ready   (in_ready)
      );
    end else begin : g_noskid
      assign in_ready  = !out_valid | out_ready;
      assign skid_data = '0;
      assign skid_ctrl = '0;
    end
  endgenerate

  // State and output entry registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= EMPTY;
      data_q <= '0;
      ctrl_q <= BUBBLE_CTRL;
    end else begin
      state  <= next_state;
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end

  // Next state and output entry: flush beats clr_ctrl beats normal advance
  always_comb begin
    next_state = state;
    data_d     = data_q;
    ctrl_d     = ctrl_q;
    skid_load  = 1'b0;
    if (flush) begin
      next_state = EMPTY;
      data_d     = '0;
      ctrl_d     = BUBBLE_CTRL;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            next_state = MAIN;
            data_d     = in_data;
            ctrl_d     = in_ctrl;
          end
        end
        MAIN: begin
          if (in_xfer && out_xfer) begin
            data_d = in_data;
            ctrl_d = in_ctrl;
          end else if (in_xfer) begin
            if (SKID != 0) begin
              next_state = FULL;
            end
            skid_load = 1'b1;
          end else if (out_xfer) begin
            next_state = EMPTY;
            ctrl_d     = BUBBLE_CTRL;
          end
        end
        FULL: begin
          if (out_xfer) begin
            next_state = MAIN;
            data_d     = skid_data;
            ctrl_d     = skid_ctrl;
          end
        end
        default: begin
          next_state = EMPTY;
        end
      endcase
      if (clr_ctrl && out_valid && !out_ready) begin
        ctrl_d = ctrl_q & ~CLR_MASK;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one skid instance and one
// single-entry instance sharing clock and reset.
module tb_pipe_stage_reg;

  localparam int          DW   = 16;
  localparam int          CW   = 16;
  localparam logic [15:0] BUB  = 16'h0033;
  localparam logic [15:0] MASK = 16'h0006;

  logic CLK  = 1'b0;
  logic nRST = 1'b1;

  logic          s_flush, s_clr, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [DW-1:0] s_in_data, s_out_data;
  logic [CW-1:0] s_in_ctrl, s_out_ctrl;
  logic [1:0]    s_occ;

  logic          n_flush, n_clr, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [DW-1:0] n_in_data, n_out_data;
  logic [CW-1:0] n_in_ctrl, n_out_ctrl;
  logic [1:0]    n_occ;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pipe_stage_reg #(
    .DATA_W (DW), .CTRL_W (CW), .BUBBLE_CTRL (BUB), .CLR_MASK (MASK), .SKID (1)
  ) dut_s (
    .CLK (CLK), .nRST (nRST), .flush (s_flush), .clr_ctrl (s_clr),
    .in_valid (s_in_valid), .in_ready (s_in_ready), .in_data (s_in_data),
    .in_ctrl (s_in_ctrl), .out_valid (s_out_valid), .out_ready (s_out_ready),
    .out_data (s_out_data), .out_ctrl (s_out_ctrl), .occupancy (s_occ)
  );

  pipe_stage_reg #(
    .DATA_W (DW), .CTRL_W (CW), .BUBBLE_CTRL (BUB), .CLR_MASK (MASK), .SKID (0)
  ) dut_n (
    .CLK (CLK), .nRST (nRST), .flush (n_flush), .clr_ctrl (n_clr),
    .in_valid (n_in_valid), .in_ready (n_in_ready), .in_data (n_in_data),
    .in_ctrl (n_in_ctrl), .out_valid (n_out_valid), .out_ready (n_out_ready),
    .out_data (n_out_data), .out_ctrl (n_out_ctrl), .occupancy (n_occ)
  );

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive all inputs of the skid instance for the next clock edge
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [15:0] c,
                               input logic ordy, input logic fl, input logic clr);
    s_in_valid  = v;
    s_in_data   = d;
    s_in_ctrl   = c;
    s_out_ready = ordy;
    s_flush     = fl;
    s_clr       = clr;
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic        m_valid;
    logic [15:0] m_data;
    logic        exp_ready;
    logic        in_x;
    int          next_send;
    int          recv;

    applyStimulus(0, 0, 0, 0, 0, 0);
    n_flush = 0; n_clr = 0; n_in_valid = 0; n_in_data = 0; n_in_ctrl = 0; n_out_ready = 0;

    // Power-on reset
    #1 nRST = 1'b0;
    #2;
    checkOutput("rst_valid", 32'(s_out_valid), 32'h0);
    checkOutput("rst_ctrl", 32'(s_out_ctrl), 32'h0033);
    checkOutput("rst_occ", 32'(s_occ), 32'h0);
    checkOutput("rst_data", 32'(s_out_data), 32'h0);
    checkOutput("rst_ready", 32'(s_in_ready), 32'h1);
    checkOutput("rst_n_ready", 32'(n_in_ready), 32'h1);
    @(negedge CLK);
    nRST = 1'b1;

    // Back-to-back streaming, one cycle latency
    for (int i = 0; i <= 8; i++) begin
      @(negedge CLK);
      if (i > 0) begin
        checkOutput("stream_valid", 32'(s_out_valid), 32'h1);
        checkOutput("stream_data", 32'(s_out_data), 32'(32'h00A0 + i));
        checkOutput("stream_occ", 32'(s_occ), 32'h1);
        checkOutput("stream_ready", 32'(s_in_ready), 32'h1);
      end
      if (i < 8) applyStimulus(1, 16'(16'h00A1 + i), 16'(i), 1, 0, 0);
      else       applyStimulus(0, 0, 0, 1, 0, 0);
    end
    @(negedge CLK);
    checkOutput("drain_valid", 32'(s_out_valid), 32'h0);
    checkOutput("drain_occ", 32'(s_occ), 32'h0);
    checkOutput("drain_ctrl", 32'(s_out_ctrl), 32'h0033);
    checkOutput("drain_data", 32'(s_out_data), 32'h00A8);

    // Asynchronous reset mid-stream
    applyStimulus(1, 16'h00C1, 16'h0044, 1, 0, 0);
    @(negedge CLK);
    checkOutput("prerst_data", 32'(s_out_data), 32'h00C1);
    applyStimulus(1, 16'h00C2, 16'h0045, 1, 0, 0);
    #2 nRST = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(s_out_valid), 32'h0);
    checkOutput("arst_ctrl", 32'(s_out_ctrl), 32'h0033);
    checkOutput("arst_occ", 32'(s_occ), 32'h0);
    checkOutput("arst_data", 32'(s_out_data), 32'h0);
    checkOutput("arst_ready", 32'(s_in_ready), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    nRST = 1'b1;

    // Backpressure fills the skid entry
    applyStimulus(1, 16'h00B1, 16'h0011, 0, 0, 0);
    @(negedge CLK);
    checkOutput("bp1_valid", 32'(s_out_valid), 32'h1);
    checkOutput("bp1_data", 32'(s_out_data), 32'h00B1);
    checkOutput("bp1_occ", 32'(s_occ), 32'h1);
    checkOutput("bp1_ready", 32'(s_in_ready), 32'h1);
    applyStimulus(1, 16'h00B2, 16'h0012, 0, 0, 0);
    @(negedge CLK);
    checkOutput("bp2_occ", 32'(s_occ), 32'h2);
    checkOutput("bp2_ready", 32'(s_in_ready), 32'h0);
    checkOutput("bp2_data", 32'(s_out_data), 32'h00B1);
    applyStimulus(1, 16'h00B3, 16'h0013, 0, 0, 0);
    @(negedge CLK);
    checkOutput("bp3_occ", 32'(s_occ), 32'h2);
    checkOutput("bp3_data", 32'(s_out_data), 32'h00B1);
    checkOutput("bp3_ctrl", 32'(s_out_ctrl), 32'h0011);
    applyStimulus(0, 0, 0, 1, 0, 0);
    @(negedge CLK);
    checkOutput("bp4_data", 32'(s_out_data), 32'h00B2);
    checkOutput("bp4_ctrl", 32'(s_out_ctrl), 32'h0012);
    checkOutput("bp4_occ", 32'(s_occ), 32'h1);
    checkOutput("bp4_ready", 32'(s_in_ready), 32'h1);
    @(negedge CLK);
    checkOutput("bp5_valid", 32'(s_out_valid), 32'h0);
    checkOutput("bp5_occ", 32'(s_occ), 32'h0);

    // Flush while full with an entry offered
    applyStimulus(1, 16'h00D1, 16'h0021, 0, 0, 0);
    @(negedge CLK);
    applyStimulus(1, 16'h00D2, 16'h0022, 0, 0, 0);
    @(negedge CLK);
    checkOutput("flf_pre_occ", 32'(s_occ), 32'h2);
    applyStimulus(1, 16'h00D3, 16'h0023, 0, 1, 0);
    @(negedge CLK);
    checkOutput("flf_valid", 32'(s_out_valid), 32'h0);
    checkOutput("flf_occ", 32'(s_occ), 32'h0);
    checkOutput("flf_data", 32'(s_out_data), 32'h0);
    checkOutput("flf_ctrl", 32'(s_out_ctrl), 32'h0033);
    checkOutput("flf_ready", 32'(s_in_ready), 32'h1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    @(negedge CLK);
    checkOutput("flf_post_valid", 32'(s_out_valid), 32'h0);

    // Flush discards an input accepted in the same cycle
    applyStimulus(1, 16'h00D4, 16'h0024, 0, 0, 0);
    @(negedge CLK);
    applyStimulus(1, 16'h00D5, 16'h0025, 0, 1, 0);
    @(negedge CLK);
    checkOutput("flm_valid", 32'(s_out_valid), 32'h0);
    checkOutput("flm_data", 32'(s_out_data), 32'h0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    @(negedge CLK);
    checkOutput("flm_post_valid", 32'(s_out_valid), 32'h0);

    // Control-bit clear on a held entry, not on a departing one or the skid
    applyStimulus(1, 16'h00E1, 16'h00FF, 0, 0, 0);
    @(negedge CLK);
    checkOutput("clr_pre_ctrl", 32'(s_out_ctrl), 32'h00FF);
    applyStimulus(0, 0, 0, 0, 0, 1);
    @(negedge CLK);
    checkOutput("clr1_ctrl", 32'(s_out_ctrl), 32'h00F9);
    checkOutput("clr1_valid", 32'(s_out_valid), 32'h1);
    checkOutput("clr1_occ", 32'(s_occ), 32'h1);
    checkOutput("clr1_data", 32'(s_out_data), 32'h00E1);
    applyStimulus(1, 16'h00E2, 16'h00FF, 1, 0, 1);
    @(negedge CLK);
    checkOutput("clr2_ctrl", 32'(s_out_ctrl), 32'h00FF);
    checkOutput("clr2_data", 32'(s_out_data), 32'h00E2);
    applyStimulus(1, 16'h00E3, 16'h00FF, 0, 0, 1);
    @(negedge CLK);
    checkOutput("clr3_ctrl", 32'(s_out_ctrl), 32'h00F9);
    checkOutput("clr3_occ", 32'(s_occ), 32'h2);
    checkOutput("clr3_data", 32'(s_out_data), 32'h00E2);
    applyStimulus(0, 0, 0, 1, 0, 0);
    @(negedge CLK);
    checkOutput("clr4_ctrl", 32'(s_out_ctrl), 32'h00FF);
    checkOutput("clr4_data", 32'(s_out_data), 32'h00E3);
    @(negedge CLK);
    checkOutput("clr5_valid", 32'(s_out_valid), 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Single-entry stage with toggling downstream ready
    m_valid   = 1'b0;
    m_data    = '0;
    next_send = 0;
    recv      = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge CLK);
      checkOutput("n_valid", 32'(n_out_valid), 32'(m_valid));
      checkOutput("n_occ", 32'(n_occ), m_valid ? 32'h1 : 32'h0);
      if (m_valid) checkOutput("n_data", 32'(n_out_data), 32'(m_data));
      if (next_send >= 20 && !m_valid) break;
      n_out_ready = cyc[0];
      n_in_valid  = (next_send < 20);
      n_in_data   = 16'(16'h0060 + next_send);
      n_in_ctrl   = 16'(next_send);
      #1;
      exp_ready = !m_valid | n_out_ready;
      checkOutput("n_ready", 32'(n_in_ready), 32'(exp_ready));
      if (n_out_valid && n_out_ready) begin
        checkOutput("n_order", 32'(n_out_data), 32'(32'h0060 + recv));
        recv++;
      end
      in_x = n_in_valid & exp_ready;
      if (in_x) begin
        m_valid = 1'b1;
        m_data  = 16'(16'h0060 + next_send);
        next_send++;
      end else if (m_valid && n_out_ready) begin
        m_valid = 1'b0;
      end
    end
    checkOutput("n_recv", 32'(recv), 32'd20);
    n_in_valid  = 1'b0;
    n_out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
